// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and default widths for the data memory arbiter.
// The port ids are the values carried by last_grant and the latched owner of a transaction.
package data_memory_arbiter_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/data_memory_arbiter_rr_arbiter_2.sv
// Two-way combinational arbiter with a one-hot grant (bit 0 = port A, bit 1 = port B).
// On a tie, fixed priority favours A; otherwise the port that did not win last time is granted.
module rr_arbiter_2
  import data_memory_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  port_e      last_grant,
  input  logic       fixed_priority,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (fixed_priority || (last_grant == PORT_B)) begin
          grant = 2'b01;
        end else begin
          grant = 2'b10;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares a single-port data memory with registered read data between two requesters.
// Each transaction is grant -> one ACCESS cycle -> one RESP cycle carrying the done pulse.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_e              state_q, state_d;
  port_e               last_q, last_d;
  port_e               port_q, port_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          grant_s;
  logic                arb_en_s;
  logic                resp_s;

  rr_arbiter_2 u_arb (
    .req            ({b_req, a_req}),
    .last_grant     (last_q),
    .fixed_priority (FIXED_PRIORITY != 0),
    .grant          (grant_s)
  );

  // Grants are withheld during reset so a gnt never reports a latch that reset discards.
  assign arb_en_s = !rst && ((state_q == IDLE) || (state_q == RESP));
  assign resp_s   = !rst && (state_q == RESP);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    port_d  = port_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (arb_en_s && (grant_s != 2'b00)) begin
      state_d = ACCESS;
      if (grant_s[1]) begin
        port_d  = PORT_B;
        we_d    = b_we;
        addr_d  = b_addr;
        wdata_d = b_wdata;
      end else begin
        port_d  = PORT_A;
        we_d    = a_we;
        addr_d  = a_addr;
        wdata_d = a_wdata;
      end
      last_d = port_d;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ACCESS:  state_d = RESP;
        RESP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= PORT_B;
      port_q  <= PORT_A;
      we_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      port_q  <= port_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Memory address/data follow the latch, so they hold their last value outside ACCESS.
  always_comb begin
    a_gnt          = arb_en_s && grant_s[0];
    b_gnt          = arb_en_s && grant_s[1];
    mem_write      = (state_q == ACCESS) && we_q;
    mem_read       = (state_q == ACCESS) && !we_q;
    mem_address    = addr_q;
    mem_write_data = wdata_q;
    a_done         = resp_s && (port_q == PORT_A);
    b_done         = resp_s && (port_q == PORT_B);
    a_rdata        = {DATA_W{1'b0}};
    b_rdata        = {DATA_W{1'b0}};
    if (a_done && !we_q) begin
      a_rdata = mem_read_data;
    end else if (b_done && !we_q) begin
      b_rdata = mem_read_data;
    end else begin
      a_rdata = {DATA_W{1'b0}};
      b_rdata = {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: a round-robin instance (0) and a fixed-priority instance (1),
// each with its own memory, checked every cycle against a transaction-level model.
module tb_data_memory_arbiter;

  typedef struct packed {
    logic        we;
    logic [5:0]  addr;
    logic [63:0] wdata;
  } op_t;

  typedef struct {
    int          inst;
    int          port;
    int          cyc;
    logic [63:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_cmd;
  // Requester signals indexed inst*2 + port (port 0 = A, 1 = B).
  logic        req   [4];
  logic        we    [4];
  logic [5:0]  addr  [4];
  logic [63:0] wdata [4];
  logic        gnt   [4];
  logic        done  [4];
  logic [63:0] rdata [4];
  logic        mw    [2];
  logic        mr    [2];
  logic [5:0]  maddr [2];
  logic [63:0] mwd   [2];
  logic [63:0] mrd   [2];
  logic [63:0] mem   [2][64];
  logic        pl_en;
  int          pl_i;
  logic [5:0]  pl_a;
  logic [63:0] pl_d;

  op_t         opq [4][$];
  logic        gseen [4];
  ev_t         gnt_log[$];
  ev_t         done_log[$];
  int          cyc;
  int          n_tests;
  int          n_fail;

  // Model state per instance
  logic [63:0] mdl_mem [2][64];
  int          free_cyc [2];
  int          last_b   [2];
  logic        op_v   [2];
  int          op_cyc [2];
  op_t         op_r   [2];
  int          op_port[2];
  logic        dn_v   [2];
  int          dn_cyc [2];
  op_t         dn_r   [2];
  int          dn_port[2];

  always #5 clk = ~clk;

  data_memory_arbiter #(.ADDR_W(6), .DATA_W(64), .FIXED_PRIORITY(0)) u_rr (
    .clk(clk), .rst(rst),
    .a_req(req[0]), .a_we(we[0]), .a_addr(addr[0]), .a_wdata(wdata[0]),
    .a_gnt(gnt[0]), .a_done(done[0]), .a_rdata(rdata[0]),
    .b_req(req[1]), .b_we(we[1]), .b_addr(addr[1]), .b_wdata(wdata[1]),
    .b_gnt(gnt[1]), .b_done(done[1]), .b_rdata(rdata[1]),
    .mem_write(mw[0]), .mem_read(mr[0]), .mem_address(maddr[0]),
    .mem_write_data(mwd[0]), .mem_read_data(mrd[0])
  );

  data_memory_arbiter #(.ADDR_W(6), .DATA_W(64), .FIXED_PRIORITY(1)) u_fp (
    .clk(clk), .rst(rst),
    .a_req(req[2]), .a_we(we[2]), .a_addr(addr[2]), .a_wdata(wdata[2]),
    .a_gnt(gnt[2]), .a_done(done[2]), .a_rdata(rdata[2]),
    .b_req(req[3]), .b_we(we[3]), .b_addr(addr[3]), .b_wdata(wdata[3]),
    .b_gnt(gnt[3]), .b_done(done[3]), .b_rdata(rdata[3]),
    .mem_write(mw[1]), .mem_read(mr[1]), .mem_address(maddr[1]),
    .mem_write_data(mwd[1]), .mem_read_data(mrd[1])
  );

  // Single-port memories with registered read data
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pl_en && (pl_i == i)) mem[i][pl_a] <= pl_d;
      if (mw[i]) mem[i][maddr[i]] <= mwd[i];
      if (mr[i]) mrd[i] <= mem[i][maddr[i]];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model; also logs what the DUTs did.
  task automatic check();
    int          b;
    int          win;
    logic [1:0]  eg;
    logic [1:0]  ed;
    logic        ew, er;
    logic [63:0] ev;
    for (int i = 0; i < 2; i++) begin
      b   = i * 2;
      win = -1;
      eg  = 2'b00;
      ed  = 2'b00;
      ew  = 1'b0;
      er  = 1'b0;
      ev  = 64'h0;
      if (!rst && (cyc >= free_cyc[i])) begin
        if (req[b] && req[b+1]) win = (i == 1) ? 0 : ((last_b[i] == 1) ? 0 : 1);
        else if (req[b]) win = 0;
        else if (req[b+1]) win = 1;
      end
      if (win >= 0) eg[win] = 1'b1;
      chk($sformatf("i%0d a_gnt", i), 64'(gnt[b]), 64'(eg[0]));
      chk($sformatf("i%0d b_gnt", i), 64'(gnt[b+1]), 64'(eg[1]));
      if (op_v[i] && (op_cyc[i] == cyc)) begin
        ew = op_r[i].we;
        er = !op_r[i].we;
        chk($sformatf("i%0d mem_address", i), 64'(maddr[i]), 64'(op_r[i].addr));
        if (op_r[i].we) begin
          chk($sformatf("i%0d mem_write_data", i), mwd[i], op_r[i].wdata);
          mdl_mem[i][op_r[i].addr] = op_r[i].wdata;
        end
        op_v[i]    = 1'b0;
        dn_v[i]    = 1'b1;
        dn_cyc[i]  = cyc + 1;
        dn_r[i]    = op_r[i];
        dn_port[i] = op_port[i];
      end
      chk($sformatf("i%0d mem_write", i), 64'(mw[i]), 64'(ew));
      chk($sformatf("i%0d mem_read", i), 64'(mr[i]), 64'(er));
      if (dn_v[i] && (dn_cyc[i] == cyc)) begin
        if (!rst) begin
          ed[dn_port[i]] = 1'b1;
          ev = dn_r[i].we ? 64'h0 : mdl_mem[i][dn_r[i].addr];
        end
        dn_v[i] = 1'b0;
      end
      chk($sformatf("i%0d a_done", i), 64'(done[b]), 64'(ed[0]));
      chk($sformatf("i%0d b_done", i), 64'(done[b+1]), 64'(ed[1]));
      chk($sformatf("i%0d a_rdata", i), rdata[b], ed[0] ? ev : 64'h0);
      chk($sformatf("i%0d b_rdata", i), rdata[b+1], ed[1] ? ev : 64'h0);
      if (win >= 0) begin
        last_b[i]   = win;
        op_v[i]     = 1'b1;
        op_cyc[i]   = cyc + 1;
        op_r[i]     = '{we[b+win], addr[b+win], wdata[b+win]};
        op_port[i]  = win;
        free_cyc[i] = cyc + 2;
      end
      if (rst) begin
        free_cyc[i] = cyc + 1;
        last_b[i]   = 1;
        op_v[i]     = 1'b0;
        dn_v[i]     = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (gnt[b+p]) begin
          gseen[b+p] = 1'b1;
          gnt_log.push_back('{i, p, cyc, 64'h0});
        end
        if (done[b+p]) done_log.push_back('{i, p, cyc, rdata[b+p]});
      end
    end
  endtask

  // Requesters: present the head op until granted, then scramble the inputs.
  task automatic drive();
    rst = rst_cmd;
    for (int k = 0; k < 4; k++) begin
      if (gseen[k]) begin
        gseen[k] = 1'b0;
        if (opq[k].size() > 0) void'(opq[k].pop_front());
        addr[k]  = addr[k] + 6'd2;
        wdata[k] = ~wdata[k];
      end
      if (opq[k].size() > 0) begin
        req[k]   = 1'b1;
        we[k]    = opq[k][0].we;
        addr[k]  = opq[k][0].addr;
        wdata[k] = opq[k][0].wdata;
      end else begin
        req[k] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    drive();
    @(negedge clk);
    check();
  endtask

  function automatic logic busy();
    logic r = 1'b0;
    for (int k = 0; k < 4; k++) if ((opq[k].size() > 0) || req[k]) r = 1'b1;
    for (int i = 0; i < 2; i++) if (op_v[i] || dn_v[i]) r = 1'b1;
    return r;
  endfunction

  task automatic run(input int bound);
    int n = 0;
    while (busy() && (n < bound)) begin
      tick();
      n++;
    end
    chk("run_timeout", 64'(busy()), 64'h0);
  endtask

  task automatic preload(input int i, input logic [5:0] a, input logic [63:0] d);
    pl_en = 1'b1;
    pl_i  = i;
    pl_a  = a;
    pl_d  = d;
    mdl_mem[i][a] = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_cmd = 1'b1;
    tick();
    tick();
    rst_cmd = 1'b0;
    tick();
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    done_log.delete();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst     = 1'b1;
    rst_cmd = 1'b1;
    pl_en   = 1'b0;
    pl_i    = 0;
    pl_a    = 6'd0;
    pl_d    = 64'h0;
    for (int k = 0; k < 4; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = 6'd0; wdata[k] = 64'h0; gseen[k] = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      free_cyc[i] = 0; last_b[i] = 1; op_v[i] = 1'b0; dn_v[i] = 1'b0;
      op_cyc[i] = 0; dn_cyc[i] = 0; op_port[i] = 0; dn_port[i] = 0;
      op_r[i] = '0; dn_r[i] = '0;
      for (int a = 0; a < 64; a++) mdl_mem[i][a] = 64'h0;
    end

    // Reset: first cycle after reset everything is quiet and the latch is cleared
    do_reset();
    for (int k = 0; k < 4; k++) begin
      chk("rst gnt", 64'(gnt[k]), 64'h0);
      chk("rst done", 64'(done[k]), 64'h0);
    end
    chk("rst mem_write", 64'(mw[0] | mw[1]), 64'h0);
    chk("rst mem_read", 64'(mr[0] | mr[1]), 64'h0);
    chk("rst mem_address", 64'(maddr[0]), 64'h0);

    // Single A read of addr 5: gnt at c, mem_read at c+1, done at c+2 with DEAD
    preload(0, 6'd5, 64'hDEAD);
    preload(0, 6'd7, 64'h7777);
    preload(0, 6'd9, 64'h9999);
    preload(0, 6'd3, 64'h3333);
    clear_logs();
    opq[0].push_back('{1'b0, 6'd5, 64'h0});
    run(20);
    chk("t1 gnt count", 64'(gnt_log.size()), 64'd1);
    chk("t1 done count", 64'(done_log.size()), 64'd1);
    if ((gnt_log.size() == 1) && (done_log.size() == 1)) begin
      chk("t1 done port", 64'(done_log[0].port), 64'd0);
      chk("t1 latency", 64'(done_log[0].cyc - gnt_log[0].cyc), 64'd2);
      chk("t1 rdata", done_log[0].data, 64'hDEAD);
    end

    // A write 1234 to 10 then read 10, back to back
    clear_logs();
    opq[0].push_back('{1'b1, 6'd10, 64'h1234});
    opq[0].push_back('{1'b0, 6'd10, 64'h0});
    run(20);
    chk("t2 done count", 64'(done_log.size()), 64'd2);
    if ((done_log.size() == 2) && (gnt_log.size() == 2)) begin
      chk("t2 done0 cyc", 64'(done_log[0].cyc - gnt_log[0].cyc), 64'd2);
      chk("t2 done1 cyc", 64'(done_log[1].cyc - gnt_log[0].cyc), 64'd4);
      chk("t2 write rdata", done_log[0].data, 64'h0);
      chk("t2 read back", done_log[1].data, 64'h1234);
    end

    // Round-robin with both requesting continuously: A,B,A,B every 2 cycles
    do_reset();
    clear_logs();
    opq[0].push_back('{1'b0, 6'd5, 64'h0});
    opq[0].push_back('{1'b0, 6'd10, 64'h0});
    opq[1].push_back('{1'b1, 6'd20, 64'hB0B0});
    opq[1].push_back('{1'b0, 6'd20, 64'h0});
    run(30);
    chk("t3 gnt count", 64'(gnt_log.size()), 64'd4);
    chk("t3 done count", 64'(done_log.size()), 64'd4);
    if ((gnt_log.size() == 4) && (done_log.size() == 4)) begin
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("t3 gnt%0d port", n), 64'(gnt_log[n].port), 64'(n % 2));
        chk($sformatf("t3 gnt%0d cyc", n), 64'(gnt_log[n].cyc - gnt_log[0].cyc), 64'(2 * n));
        chk($sformatf("t3 done%0d port", n), 64'(done_log[n].port), 64'(n % 2));
      end
      chk("t3 a rd5", done_log[0].data, 64'hDEAD);
      chk("t3 b wr", done_log[1].data, 64'h0);
      chk("t3 a rd10", done_log[2].data, 64'h1234);
      chk("t3 b rd20", done_log[3].data, 64'hB0B0);
    end

    // Fixed priority: A wins every tie; B only once A stops requesting
    clear_logs();
    opq[2].push_back('{1'b1, 6'd1, 64'h11});
    opq[2].push_back('{1'b1, 6'd2, 64'h22});
    opq[2].push_back('{1'b0, 6'd1, 64'h0});
    opq[3].push_back('{1'b0, 6'd2, 64'h0});
    run(30);
    chk("t4 gnt count", 64'(gnt_log.size()), 64'd4);
    if ((gnt_log.size() == 4) && (done_log.size() == 4)) begin
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("t4 gnt%0d inst", n), 64'(gnt_log[n].inst), 64'd1);
        chk($sformatf("t4 gnt%0d port", n), 64'(gnt_log[n].port), 64'((n == 3) ? 1 : 0));
      end
      chk("t4 b after a", 64'(gnt_log[3].cyc - gnt_log[2].cyc), 64'd2);
      chk("t4 a rd1", done_log[2].data, 64'h11);
      chk("t4 b rd2", done_log[3].data, 64'h22);
    end

    // Reset held over the ACCESS cycle of a B write to addr 3: the memory already saw
    // mem_write in that cycle, so the new value lands, but no done is ever reported.
    clear_logs();
    opq[1].push_back('{1'b1, 6'd3, 64'h5555});
    for (int n = 0; (n < 10) && (gnt_log.size() == 0); n++) tick();
    chk("t5 granted", 64'(gnt_log.size()), 64'd1);
    rst_cmd = 1'b1;
    tick();
    chk("t5 write during rst", 64'(mw[0]), 64'h1);
    rst_cmd = 1'b0;
    tick();
    chk("t5 write dropped", 64'(mw[0]), 64'h0);
    tick();
    chk("t5 no done", 64'(done_log.size()), 64'd0);
    chk("t5 addr3", mem[0][3], 64'h5555);

    // B changes address after its grant; the access still uses the granted one (7)
    clear_logs();
    opq[1].push_back('{1'b0, 6'd7, 64'h0});
    run(20);
    chk("t6 done count", 64'(done_log.size()), 64'd1);
    if (done_log.size() == 1) begin
      chk("t6 done port", 64'(done_log[0].port), 64'd1);
      chk("t6 rdata", done_log[0].data, 64'h7777);
    end
    chk("t6 addr moved", 64'(addr[1]), 64'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
